data_island_packet_assembler: RTL and testbench
===============================================

// Module: data_island_packet_assembler
// PURPOSE
//  Downstream of the packet picker in the HDMI data-island path.
//  Owns the 32-cycle packet slot counter and drives packet_enable so the picker can choose the next packet.
//  Takes the picker's 24-bit header and 4x56-bit subpackets and serialises them with BCH(32,24)/(64,56) ECC parity.
//  Output is 9 bits per pixel clock, feeding the TERC4 data-island encoders.
// PARAMETERS
//  BCH_POLY  8'h83  feedback mask for the serial BCH update (x^8+x^7+x^6+1 folded, LSB-first)
// PORTS
//  clk_pixel             in   1    pixel clock; sole clock
//  reset                 in   1    synchronous, active-high
//  data_island_next      in   1    1-cycle pulse on the cycle before data_island_period rises
//  data_island_period    in   1    high for every data-island payload cycle (N*32 cycles)
//  header                in   24   packet header from picker, valid from counter==0 of each slot
//  sub                   in   224  4 subpackets {sub3,sub2,sub1,sub0}, 56b each, same timing as header
//  packet_enable         out  1    request to picker to select the next packet
//  packet_pixel_counter  out  5    slot position 0..31
//  packet_data           out  9    {sub3..0 odd bit, sub3..0 even bit, header bit}
// BEHAVIOUR
//  Clocking, reset and counter
//  - Single clock, synchronous active-high reset.
//  - Reset state: counter=0, all ECC regs=0, hold regs=0, so packet_enable=0 and packet_data=0.
//  - Counter: increments while data_island_period=1, wrapping 31->0.
//    Forced to 0 whenever data_island_period=0, including mid-slot drop (partial packet abandoned).
//  - packet_enable (combinational) = data_island_next | (data_island_period & counter==31).
//    The picker registers its choice on this edge, so header/sub are valid at the next counter==0.
//  Capture
//  - At counter==0: live header/sub are used directly and also copied to hold regs.
//  - Counters 1..31: hold regs are used; input changes after counter 0 are ignored.
//  Serial ECC step
//  - step(e,b) = (e>>1) ^ ((e[0]^b) ? BCH_POLY : 0).
//  - Header ECC h: at counter c<24, h <= step(c==0 ? 0 : h, hdr[c]). Frozen for c>=24.
//  - Sub ECC s[k], k=0..3, at counter c<28:
//    s[k] <= step(step(c==0 ? 0 : s[k], sub_k[2c]), sub_k[2c+1]).
//    Frozen for c>=28.
//  Output mapping
//  - packet_data (combinational from counter, hold regs and ECC regs), valid when data_island_period=1:
//    [0]   = c<24 ? hdr[c] : h[c-24]
//    [k+1] = c<28 ? sub_k[2c]   : s[k][2(c-28)]
//    [k+5] = c<28 ? sub_k[2c+1] : s[k][2(c-28)+1]
//    At c==0 the header/sub bits come from the live inputs.
//  - packet_data = 0 whenever data_island_period=0.
//  Boundary cases
//  - Back-to-back packets: ECC re-seeds to 0 at each counter==0; there is no carry between packets.
//  - Reset during an island: all state returns to reset values next cycle; packet_enable=0 until the next
//    data_island_next, or until counter reaches 31 again.
//  - data_island_next coinciding with data_island_period=1 is illegal; assert in simulation.
// TESTING
//  1 reset, then island of 32 cycles, header=0, sub=0 -> packet_data=0 on all 32 cycles; packet_enable high
//    on the next pulse and at c=31.
//  2 header=24'h800000, sub=0 -> bit0 is 0 for c<23, 1 at c=23; parity bits at c=24..31 read 1,1,0,0,0,0,0,1 (8'h83).
//  3 sub0 with only bit 55 set -> bit5 at c=27 is 1; s[0]=8'h83 emitted at c=28..31 as
//    bits[1]/[5] = (1,1),(0,0),(0,0),(0,1).
//  4 64-cycle island with two different random packets -> each matches the golden BCH model independently;
//    packet_enable pulses at c=31 of packet 1; header changed at c=5 is ignored.
//  5 data_island_period dropped at c=12 -> counter=0 and packet_data=0 next cycle; a fresh island produces
//    correct ECC.
//  6 reset asserted at c=20 -> all outputs 0 the next cycle; no stale ECC in the following packet.

Source files
------------

// File: rtl/data_island_packet_assembler_if.sv
// ----------------------------------------------------------------------------
// data_island_packet_assembler_if
//
// Purpose:
//   Groups the data-island timing strobes, the picker's packet contents and
//   the assembler's serialised output into one bundle.
//
// Signals:
//   data_island_next      1    pulse on the cycle before the island starts
//   data_island_period    1    high on every data-island payload cycle
//   header                24   packet header from the picker
//   sub                   224  {sub3, sub2, sub1, sub0}, 56 bits each
//   packet_enable         1    request to the picker for the next packet
//   packet_pixel_counter  5    slot position 0..31
//   packet_data           9    {sub odd bits, sub even bits, header bit}
//
// Modports:
//   master  timing source / picker side (drives strobes and packet contents)
//   slave   assembler side (drives enable, counter and serial data)
// ----------------------------------------------------------------------------
interface data_island_packet_assembler_if;

  logic         data_island_next;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic         packet_enable;
  logic [4:0]   packet_pixel_counter;
  logic [8:0]   packet_data;

  modport master (
    output data_island_next,
    output data_island_period,
    output header,
    output sub,
    input  packet_enable,
    input  packet_pixel_counter,
    input  packet_data
  );

  modport slave (
    input  data_island_next,
    input  data_island_period,
    input  header,
    input  sub,
    output packet_enable,
    output packet_pixel_counter,
    output packet_data
  );

endinterface

// File: rtl/data_island_packet_assembler.sv
// ----------------------------------------------------------------------------
// data_island_packet_assembler
//
// Purpose:
//   Sits downstream of the packet picker in the HDMI data-island path. Owns
//   the 32-cycle packet slot counter, requests the next packet from the
//   picker, and serialises the 24-bit header plus four 56-bit subpackets with
//   their BCH(32,24) / BCH(64,56) parity, 9 bits per pixel clock, towards the
//   TERC4 data-island encoders.
//
// Parameters:
//   BCH_POLY   feedback mask for the LSB-first serial BCH update
//
// Ports:
//   clk_pixel  in   pixel clock, the only clock
//   reset      in   synchronous, active-high
//   bus        slave modport of data_island_packet_assembler_if
//                (strobes and packet contents in; packet_enable,
//                 packet_pixel_counter and packet_data out)
// ----------------------------------------------------------------------------
module data_island_packet_assembler #(
  parameter logic [7:0] BCH_POLY = 8'h83
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  data_island_packet_assembler_if.slave       bus
);

  // One serial BCH step: shift the remainder right and fold in the feedback
  // polynomial when the outgoing remainder bit disagrees with the data bit.
  function automatic logic [7:0] bchStep(input logic [7:0] ecc, input logic dataBit);
    logic [7:0] feedback;
    feedback = (ecc[0] ^ dataBit) ? BCH_POLY : 8'h00;
    return (ecc >> 1) ^ feedback;
  endfunction

  logic [4:0]       counter_q, counter_d;
  logic [23:0]      hdrHold_q, hdrHold_d;
  logic [223:0]     subHold_q, subHold_d;
  logic [7:0]       hdrEcc_q, hdrEcc_d;
  logic [3:0][7:0]  subEcc_q, subEcc_d;

  logic             slotStart;
  logic [23:0]      hdrCur;
  logic [3:0][55:0] subCur;
  logic [5:0]       evenIdx;
  logic [5:0]       oddIdx;
  logic [55:0]      laneNext;
  logic [7:0]       eccSeed;
  logic [55:0]      laneOut;
  logic             hdrOut;
  logic [3:0]       evenOut;
  logic [3:0]       oddOut;
  logic [8:0]       packetData;

  // At slot position 0 the picker's outputs are consumed live (they are only
  // captured into the hold registers on that same edge); every later position
  // works from the hold registers so the picker is free to move on.
  assign slotStart = (counter_q == 5'd0);
  assign hdrCur    = slotStart ? bus.header : hdrHold_q;
  assign subCur    = slotStart ? bus.sub    : subHold_q;
  assign evenIdx   = {counter_q, 1'b0};
  assign oddIdx    = {counter_q, 1'b1};

  // Next-state logic: the slot counter runs only inside the island and is
  // forced to 0 outside it, which also abandons a partially sent packet.
  // Parity remainders restart from zero at position 0 so packets never share
  // ECC state, and freeze once their data bits have all been absorbed.
  always_comb begin
    counter_d = counter_q;
    hdrHold_d = hdrHold_q;
    subHold_d = subHold_q;
    hdrEcc_d  = hdrEcc_q;
    subEcc_d  = subEcc_q;
    laneNext  = '0;
    eccSeed   = '0;

    if (bus.data_island_period) begin
      counter_d = counter_q + 5'd1;

      if (slotStart) begin
        hdrHold_d = bus.header;
        subHold_d = bus.sub;
      end

      if (counter_q < 5'd24) begin
        hdrEcc_d = bchStep(slotStart ? 8'h00 : hdrEcc_q, hdrCur[counter_q]);
      end

      if (counter_q < 5'd28) begin
        for (int k = 0; k < 4; k++) begin
          laneNext = subCur[2'(k)];
          eccSeed  = slotStart ? 8'h00 : subEcc_q[2'(k)];
          subEcc_d[2'(k)] = bchStep(bchStep(eccSeed, laneNext[evenIdx]), laneNext[oddIdx]);
        end
      end
    end else begin
      counter_d = 5'd0;
    end
  end

  // State registers with synchronous reset back to an all-zero idle state.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter_q <= '0;
      hdrHold_q <= '0;
      subHold_q <= '0;
      hdrEcc_q  <= '0;
      subEcc_q  <= '0;
    end else begin
      counter_q <= counter_d;
      hdrHold_q <= hdrHold_d;
      subHold_q <= subHold_d;
      hdrEcc_q  <= hdrEcc_d;
      subEcc_q  <= subEcc_d;
    end
  end

  // Output serialiser: data bits first, then parity. Parity positions reuse
  // the low counter bits directly, since 24..31 minus 24 equals counter[2:0]
  // and 28..31 minus 28 equals counter[1:0].
  always_comb begin
    hdrOut     = 1'b0;
    evenOut    = '0;
    oddOut     = '0;
    laneOut    = '0;
    packetData = '0;

    if (bus.data_island_period) begin
      hdrOut = (counter_q < 5'd24) ? hdrCur[counter_q] : hdrEcc_q[counter_q[2:0]];

      for (int k = 0; k < 4; k++) begin
        laneOut = subCur[2'(k)];
        if (counter_q < 5'd28) begin
          evenOut[2'(k)] = laneOut[evenIdx];
          oddOut[2'(k)]  = laneOut[oddIdx];
        end else begin
          evenOut[2'(k)] = subEcc_q[2'(k)][{counter_q[1:0], 1'b0}];
          oddOut[2'(k)]  = subEcc_q[2'(k)][{counter_q[1:0], 1'b1}];
        end
      end

      packetData = {oddOut, evenOut, hdrOut};
    end
  end

  assign bus.packet_enable        = bus.data_island_next |
                                    (bus.data_island_period & (counter_q == 5'd31));
  assign bus.packet_pixel_counter = counter_q;
  assign bus.packet_data          = packetData;

  // The island request pulse must precede the island, never overlap it.
  assert property (@(posedge clk_pixel) disable iff (reset)
                   !(bus.data_island_next && bus.data_island_period));

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// ----------------------------------------------------------------------------
// tb_data_island_packet_assembler
//
// Purpose:
//   Self-checking bench for data_island_packet_assembler. Each packet is
//   modelled as whole BCH codewords: the header codeword is {parity, header}
//   sent one bit per slot position, each subpacket codeword is
//   {parity, sub_k} sent two bits per position. The slot position is tracked
//   from the strobes the bench itself drives.
// ----------------------------------------------------------------------------
module tb_data_island_packet_assembler;

  logic clk_pixel = 1'b0;
  logic reset;

  data_island_packet_assembler_if bus ();

  data_island_packet_assembler #(
    .BCH_POLY (8'h83)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int           vectors     = 0;
  int           miscompares = 0;

  logic [4:0]   mCount;
  logic [23:0]  mHdr;
  logic [223:0] mSub;
  logic         lastPer;
  logic         lastRst;
  logic [8:0]   expData;
  logic         expEn;

  // BCH remainder of the first n bits of a message, LSB first,
  // generator x^8+x^7+x^6+1 in reflected form.
  function automatic logic [7:0] bchOf(input logic [63:0] bits, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (e[0] ^ bits[6'(i)]) e = (e >> 1) ^ 8'h83;
      else                    e = e >> 1;
    end
    return e;
  endfunction

  // Expected 9-bit word for slot position c of a packet.
  function automatic logic [8:0] expectedWord(input logic [23:0] h, input logic [223:0] s,
                                              input logic [4:0] c);
    logic [31:0]      hcw;
    logic [63:0]      scw;
    logic [3:0][55:0] lanes;
    logic [3:0]       ev;
    logic [3:0]       od;
    hcw   = {bchOf({40'h0, h}, 24), h};
    lanes = s;
    ev    = '0;
    od    = '0;
    for (int k = 0; k < 4; k++) begin
      scw = {bchOf({8'h0, lanes[2'(k)]}, 56), lanes[2'(k)]};
      ev[2'(k)] = scw[{c, 1'b0}];
      od[2'(k)] = scw[{c, 1'b1}];
    end
    return {od, ev, hcw[c]};
  endfunction

  function automatic logic [223:0] randSub();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle's inputs, move to the sampling point and predict outputs.
  task automatic applyStimulus(input logic nxt, input logic per, input logic rst,
                               input logic [23:0] h, input logic [223:0] s);
    reset                  = rst;
    bus.data_island_next   = nxt;
    bus.data_island_period = per;
    bus.header             = h;
    bus.sub                = s;
    lastPer                = per;
    lastRst                = rst;
    @(negedge clk_pixel);
    if (per && mCount == 5'd0) begin
      mHdr = h;
      mSub = s;
    end
    expEn   = nxt | (per && mCount == 5'd31);
    expData = per ? expectedWord(mHdr, mSub, mCount) : 9'h000;
  endtask

  // Advance across the active edge and step the slot-position model.
  task automatic finishCycle();
    @(posedge clk_pixel);
    if (lastRst || !lastPer) mCount = 5'd0;
    else                     mCount = mCount + 5'd1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_island_next   = 1'b0;
    bus.data_island_period = 1'b0;
    bus.header = '0;
    bus.sub    = '0;
    repeat (2) @(posedge clk_pixel);
    #1;
    mCount = 5'd0;
    mHdr   = '0;
    mSub   = '0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 24'h0, 224'h0);
      vectors++;
      if (bus.packet_pixel_counter !== 5'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_counter got=%0d exp=0", bus.packet_pixel_counter);
      end
      vectors++;
      if (bus.packet_enable !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_enable got=%b exp=0", bus.packet_enable);
      end
      vectors++;
      if (bus.packet_data !== 9'h000) begin
        miscompares++;
        $display("[TB] FAIL reset_data got=%h exp=000", bus.packet_data);
      end
      finishCycle();
    end
  endtask

  // Idle request pulse, a full all-zero packet, then one idle cycle.
  task automatic test_zero_packet();
    for (int cyc = 0; cyc < 34; cyc++) begin
      if (cyc == 0)       applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, 224'h0);
      else if (cyc == 33) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 224'h0);
      else                applyStimulus(1'b0, 1'b1, 1'b0, 24'h0, 224'h0);
      vectors++;
      if (bus.packet_pixel_counter !== mCount) begin
        miscompares++;
        $display("[TB] FAIL zero_counter cyc=%0d got=%0d exp=%0d", cyc, bus.packet_pixel_counter, mCount);
      end
      vectors++;
      if (bus.packet_enable !== expEn) begin
        miscompares++;
        $display("[TB] FAIL zero_enable cyc=%0d got=%b exp=%b", cyc, bus.packet_enable, expEn);
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL zero_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
  endtask

  // Header MSB only: the header parity remainder must be exactly the polynomial.
  task automatic test_header_msb();
    logic [7:0] parity;
    logic       bit23;
    parity = '0;
    bit23  = 1'b0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      if (cyc == 0)       applyStimulus(1'b1, 1'b0, 1'b0, 24'h800000, 224'h0);
      else if (cyc == 33) applyStimulus(1'b0, 1'b0, 1'b0, 24'h800000, 224'h0);
      else                applyStimulus(1'b0, 1'b1, 1'b0, 24'h800000, 224'h0);
      if (cyc == 24) bit23 = bus.packet_data[0];
      if (cyc >= 25 && cyc <= 32) parity[3'(cyc - 25)] = bus.packet_data[0];
      vectors++;
      if (bus.packet_enable !== expEn) begin
        miscompares++;
        $display("[TB] FAIL hdr_enable cyc=%0d got=%b exp=%b", cyc, bus.packet_enable, expEn);
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL hdr_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
    vectors++;
    if (bit23 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hdr_bit23 got=%b exp=1", bit23);
    end
    vectors++;
    if (parity !== 8'h83) begin
      miscompares++;
      $display("[TB] FAIL hdr_parity got=%h exp=83", parity);
    end
  endtask

  // Subpacket 0 bit 55 only: its parity remainder must be exactly the polynomial.
  task automatic test_sub_msb();
    logic [223:0] s;
    logic [3:0]   evenPar;
    logic [3:0]   oddPar;
    logic         bit55;
    s       = 224'h1 << 55;
    evenPar = '0;
    oddPar  = '0;
    bit55   = 1'b0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      if (cyc == 0)       applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, s);
      else if (cyc == 33) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, s);
      else                applyStimulus(1'b0, 1'b1, 1'b0, 24'h0, s);
      if (cyc == 28) bit55 = bus.packet_data[5];
      if (cyc >= 29 && cyc <= 32) begin
        evenPar[2'(cyc - 29)] = bus.packet_data[1];
        oddPar[2'(cyc - 29)]  = bus.packet_data[5];
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL sub_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
    vectors++;
    if (bit55 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sub_bit55 got=%b exp=1", bit55);
    end
    vectors++;
    if ({oddPar, evenPar} !== 8'b1001_0001) begin
      miscompares++;
      $display("[TB] FAIL sub_parity got=%b_%b exp=1001_0001", oddPar, evenPar);
    end
  endtask

  // Two random packets back to back; inputs are scrambled on every
  // non-capture position to prove they are ignored.
  task automatic test_back_to_back();
    logic [23:0]  hA, hB, h;
    logic [223:0] sA, sB, s;
    hA = 24'($urandom());
    hB = 24'($urandom());
    sA = randSub();
    sB = randSub();
    for (int cyc = 0; cyc < 66; cyc++) begin
      h = 24'($urandom());
      s = randSub();
      if (cyc == 1)  begin h = hA; s = sA; end
      if (cyc == 33) begin h = hB; s = sB; end
      if (cyc == 0)       applyStimulus(1'b1, 1'b0, 1'b0, h, s);
      else if (cyc == 65) applyStimulus(1'b0, 1'b0, 1'b0, h, s);
      else                applyStimulus(1'b0, 1'b1, 1'b0, h, s);
      vectors++;
      if (bus.packet_pixel_counter !== mCount) begin
        miscompares++;
        $display("[TB] FAIL b2b_counter cyc=%0d got=%0d exp=%0d", cyc, bus.packet_pixel_counter, mCount);
      end
      vectors++;
      if (bus.packet_enable !== expEn) begin
        miscompares++;
        $display("[TB] FAIL b2b_enable cyc=%0d got=%b exp=%b", cyc, bus.packet_enable, expEn);
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
  endtask

  // Island dropped at position 12, then a fresh full packet.
  // cyc 0 pulse, 1..12 positions 0..11, 13 dropped, 14 pulse, 15..46 island, 47 idle.
  task automatic test_drop();
    logic nxt, per;
    for (int cyc = 0; cyc < 48; cyc++) begin
      nxt = (cyc == 0) || (cyc == 14);
      per = (cyc >= 1 && cyc <= 12) || (cyc >= 15 && cyc <= 46);
      applyStimulus(nxt, per, 1'b0, 24'($urandom()), randSub());
      vectors++;
      if (bus.packet_pixel_counter !== mCount) begin
        miscompares++;
        $display("[TB] FAIL drop_counter cyc=%0d got=%0d exp=%0d", cyc, bus.packet_pixel_counter, mCount);
      end
      vectors++;
      if (bus.packet_enable !== expEn) begin
        miscompares++;
        $display("[TB] FAIL drop_enable cyc=%0d got=%b exp=%b", cyc, bus.packet_enable, expEn);
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL drop_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
  endtask

  // Reset at position 20 mid-island, then a fresh packet with no stale ECC.
  // cyc 0 pulse, 1..21 positions 0..20 (reset on 21), 22 idle, 23 pulse, 24..55 island, 56 idle.
  task automatic test_reset_mid();
    logic nxt, per, rst;
    for (int cyc = 0; cyc < 57; cyc++) begin
      nxt = (cyc == 0) || (cyc == 23);
      per = (cyc >= 1 && cyc <= 21) || (cyc >= 24 && cyc <= 55);
      rst = (cyc == 21);
      applyStimulus(nxt, per, rst, 24'($urandom()), randSub());
      vectors++;
      if (bus.packet_pixel_counter !== mCount) begin
        miscompares++;
        $display("[TB] FAIL rstmid_counter cyc=%0d got=%0d exp=%0d", cyc, bus.packet_pixel_counter, mCount);
      end
      vectors++;
      if (bus.packet_enable !== expEn) begin
        miscompares++;
        $display("[TB] FAIL rstmid_enable cyc=%0d got=%b exp=%b", cyc, bus.packet_enable, expEn);
      end
      vectors++;
      if (bus.packet_data !== expData) begin
        miscompares++;
        $display("[TB] FAIL rstmid_data cyc=%0d got=%h exp=%h", cyc, bus.packet_data, expData);
      end
      finishCycle();
    end
  endtask

  initial begin
    test_reset();
    test_zero_packet();
    test_header_msb();
    test_sub_msb();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
